neuron_data_feeder: RTL and testbench

NEURON_DATA_FEEDER -- requirements
Module: neuron_data_feeder

---
 rtl/neuron_data_feeder.sv | 105 ++++++++++
 tb/tb_neuron_data_feeder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_data_feeder.sv
// Sample memory and request-driven fetch sequencer feeding {x1, x2, t} training
// samples to a neuron controller, one sample per request, wrapping each epoch.
module neuron_data_feeder #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wrEn,
   input  logic [ADDR_W-1:0]        wrAddr,
   input  logic signed [DATA_W-1:0] wrX1,
   input  logic signed [DATA_W-1:0] wrX2,
   input  logic signed [DATA_W-1:0] wrT,
   input  logic                     ldCount,
   input  logic [ADDR_W:0]          cntIn,
   input  logic                     rewind,
   input  logic                     requestFlag,
   output logic                     dataReady,
   output logic signed [DATA_W-1:0] x1,
   output logic signed [DATA_W-1:0] x2,
   output logic signed [DATA_W-1:0] t,
   output logic                     flagEOF,
   output logic [ADDR_W-1:0]        sampleIdx,
   output logic                     emptyErr
);

   typedef enum logic [1:0] {IDLE, FETCH, VALID, HOLD} state_t;

   localparam logic [ADDR_W:0] ONE     = 1;
   localparam logic [ADDR_W:0] DEPTH_C = DEPTH;

   state_t                  state;
   logic [ADDR_W-1:0]       rdPtr;
   logic [ADDR_W:0]         cntReg;
   logic [3*DATA_W-1:0]     mem [DEPTH];

   logic [ADDR_W:0]         cnt_last;
   logic [ADDR_W:0]         ptr_inc;
   logic                    ptr_wrap;
   logic [ADDR_W:0]         cnt_sat;

   assign cnt_last = cntReg - ONE;
   assign ptr_inc  = {1'b0, rdPtr} + ONE;
   // Wrapping also on ptr_inc >= cntReg keeps rdPtr below cntReg even if the
   // count shrank after the fetch.
   assign ptr_wrap = flagEOF || (ptr_inc >= cntReg);
   assign cnt_sat  = (cntIn > DEPTH_C) ? DEPTH_C : cntIn;

   // NOTE: sample storage is deliberately not reset so samples survive rst;
   // without a reset it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (wrEn) mem[wrAddr] <= {wrX1, wrX2, wrT};
   end

   // NOTE: all state uses non-blocking assignments, so a FETCH reads the
   // pre-edge memory word, rdPtr and cntReg even when they are written on the
   // same edge; later assignments below override earlier ones (rewind wins).
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rdPtr     <= '0;
         cntReg    <= '0;
         dataReady <= 1'b0;
         x1        <= '0;
         x2        <= '0;
         t         <= '0;
         flagEOF   <= 1'b0;
         sampleIdx <= '0;
         emptyErr  <= 1'b0;
      end else begin
         dataReady <= 1'b0;
         case (state)
            IDLE: begin
               if (requestFlag) begin
                  if (cntReg != '0) state <= FETCH;
                  else              emptyErr <= 1'b1;
               end
            end
            FETCH: begin
               {x1, x2, t} <= mem[rdPtr];
               sampleIdx   <= rdPtr;
               flagEOF     <= ({1'b0, rdPtr} == cnt_last);
               dataReady   <= 1'b1;
               state       <= VALID;
            end
            VALID: begin
               rdPtr <= ptr_wrap ? '0 : ptr_inc[ADDR_W-1:0];
               state <= HOLD;
            end
            HOLD: begin
               if (!requestFlag) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (ldCount) begin
            cntReg   <= cnt_sat;
            emptyErr <= 1'b0;
         end
         if (ldCount || rewind) rdPtr <= '0;
      end
   end

endmodule

// File: tb/tb_neuron_data_feeder.sv
// Directed bench for neuron_data_feeder: a queue of expected samples is filled
// as each request is issued and drained when dataReady is observed.
module tb_neuron_data_feeder;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   typedef struct {
      logic signed [DATA_W-1:0] x1;
      logic signed [DATA_W-1:0] x2;
      logic signed [DATA_W-1:0] t;
      logic                     eof;
      logic [ADDR_W-1:0]        idx;
   } sample_t;

   logic                     clk;
   logic                     rst;
   logic                     wrEn;
   logic [ADDR_W-1:0]        wrAddr;
   logic signed [DATA_W-1:0] wrX1, wrX2, wrT;
   logic                     ldCount;
   logic [ADDR_W:0]          cntIn;
   logic                     rewind;
   logic                     requestFlag;
   logic                     dataReady;
   logic signed [DATA_W-1:0] x1, x2, t;
   logic                     flagEOF;
   logic [ADDR_W-1:0]        sampleIdx;
   logic                     emptyErr;

   neuron_data_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .wrEn(wrEn), .wrAddr(wrAddr), .wrX1(wrX1), .wrX2(wrX2), .wrT(wrT),
      .ldCount(ldCount), .cntIn(cntIn), .rewind(rewind),
      .requestFlag(requestFlag), .dataReady(dataReady),
      .x1(x1), .x2(x2), .t(t), .flagEOF(flagEOF),
      .sampleIdx(sampleIdx), .emptyErr(emptyErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int pulses  = 0;

   sample_t                  sb[$];
   logic signed [DATA_W-1:0] mx1 [DEPTH];
   logic signed [DATA_W-1:0] mx2 [DEPTH];
   logic signed [DATA_W-1:0] mt  [DEPTH];
   int                       exp_ptr = 0;
   int                       exp_cnt = 0;

   always @(negedge clk) if (dataReady === 1'b1) pulses++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic write_mem(input int a, input int v1, input int v2, input int vt);
      wrEn = 1'b1; wrAddr = ADDR_W'(a);
      wrX1 = DATA_W'(v1); wrX2 = DATA_W'(v2); wrT = DATA_W'(vt);
      tick();
      wrEn = 1'b0;
      mx1[a] = DATA_W'(v1); mx2[a] = DATA_W'(v2); mt[a] = DATA_W'(vt);
   endtask

   task automatic load_count(input int n);
      ldCount = 1'b1; cntIn = (ADDR_W+1)'(n);
      tick();
      ldCount = 1'b0;
      exp_cnt = (n > DEPTH) ? DEPTH : n;
      exp_ptr = 0;
   endtask

   task automatic push_expected();
      sample_t e;
      e.x1  = mx1[exp_ptr];
      e.x2  = mx2[exp_ptr];
      e.t   = mt[exp_ptr];
      e.idx = ADDR_W'(exp_ptr);
      e.eof = (exp_ptr == exp_cnt - 1);
      exp_ptr = e.eof ? 0 : exp_ptr + 1;
      sb.push_back(e);
   endtask

   task automatic compare_front(input string tag);
      sample_t e;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'(sb.size()), 1);
         return;
      end
      e = sb.pop_front();
      check({tag, "_x1"},  32'(x1), 32'(e.x1));
      check({tag, "_x2"},  32'(x2), 32'(e.x2));
      check({tag, "_t"},   32'(t), 32'(e.t));
      check({tag, "_eof"}, 32'(flagEOF), 32'(e.eof));
      check({tag, "_idx"}, 32'(sampleIdx), 32'(e.idx));
   endtask

   // One request pulse; optionally overwrite the fetched word on the FETCH
   // edge, or assert rewind during the VALID cycle.
   task automatic do_request(input string tag, input bit wr_fetch, input bit rew_valid);
      int lat;
      int widx;
      widx = exp_ptr;
      push_expected();
      requestFlag = 1'b1;
      tick();
      requestFlag = 1'b0;
      lat = 1;
      check({tag, "_early"}, 32'(dataReady), 0);
      if (wr_fetch) begin
         wrEn = 1'b1; wrAddr = ADDR_W'(widx);
         wrX1 = 8'sd7; wrX2 = 8'sd7; wrT = 8'sd7;
      end
      tick();
      lat = 2;
      wrEn = 1'b0;
      if (wr_fetch) begin
         mx1[widx] = 8'sd7; mx2[widx] = 8'sd7; mt[widx] = 8'sd7;
      end
      while (dataReady !== 1'b1 && lat < 6) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 2);
      check({tag, "_ready"}, 32'(dataReady), 1);
      compare_front(tag);
      if (rew_valid) begin
         rewind  = 1'b1;
         exp_ptr = 0;
      end
      tick();
      rewind = 1'b0;
      check({tag, "_one_cycle"}, 32'(dataReady), 0);
      tick();
   endtask

   initial begin
      int p0;
      logic signed [DATA_W-1:0] hx1, hx2, ht;
      logic [ADDR_W-1:0]        hidx;

      rst = 1'b1; wrEn = 1'b0; wrAddr = '0; wrX1 = '0; wrX2 = '0; wrT = '0;
      ldCount = 1'b0; cntIn = '0; rewind = 1'b0; requestFlag = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         mx1[i] = '0; mx2[i] = '0; mt[i] = '0;
      end
      tick(); tick();
      rst = 1'b0;
      check("rst_ready", 32'(dataReady), 0);
      check("rst_x1",    32'(x1), 0);
      check("rst_x2",    32'(x2), 0);
      check("rst_t",     32'(t), 0);
      check("rst_eof",   32'(flagEOF), 0);
      check("rst_idx",   32'(sampleIdx), 0);
      check("rst_empty", 32'(emptyErr), 0);

      // Three-sample epoch, then wrap to index 0.
      write_mem(0,  1,  2,  1);
      write_mem(1,  3, -4, -1);
      write_mem(2, -5,  6,  1);
      load_count(3);
      do_request("s0", 0, 0);
      do_request("s1", 0, 0);
      do_request("s2", 0, 0);
      do_request("wrap", 0, 0);

      // Request held high for 10 cycles is served once.
      p0 = pulses;
      push_expected();
      requestFlag = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (dataReady === 1'b1) compare_front("hold");
      end
      requestFlag = 1'b0;
      hx1 = x1; hx2 = x2; ht = t; hidx = sampleIdx;
      tick(); tick();
      check("hold_pulses", 32'(pulses - p0), 1);
      check("hold_idx_stable", 32'(sampleIdx), 32'(hidx));
      check("hold_x1_stable",  32'(x1), 32'(hx1));
      check("hold_x2_stable",  32'(x2), 32'(hx2));
      check("hold_t_stable",   32'(t), 32'(ht));
      check("hold_idx", 32'(hidx), 1);

      // Rewind outside a fetch, then rewind coincident with the VALID increment.
      rewind = 1'b1; tick(); rewind = 1'b0;
      exp_ptr = 0;
      do_request("rw0", 0, 0);
      do_request("rw1", 0, 1);
      do_request("rw_after", 0, 0);

      // Write to the fetched address on the FETCH edge returns old data.
      do_request("coll", 1, 0);
      rewind = 1'b1; tick(); rewind = 1'b0;
      exp_ptr = 0;
      do_request("coll_r0", 0, 0);
      do_request("coll_new", 0, 0);

      // Empty epoch sets the sticky error; a reload clears it.
      load_count(0);
      check("empty_clear0", 32'(emptyErr), 0);
      p0 = pulses;
      requestFlag = 1'b1; tick(); requestFlag = 1'b0;
      repeat (4) tick();
      check("empty_no_pulse", 32'(pulses - p0), 0);
      check("empty_err", 32'(emptyErr), 1);
      load_count(2);
      check("empty_reload", 32'(emptyErr), 0);
      do_request("c2_0", 0, 0);
      do_request("c2_1", 0, 0);

      // Reset landing on the FETCH edge aborts the fetch; memory is retained.
      p0 = pulses;
      requestFlag = 1'b1; tick(); requestFlag = 1'b0;
      rst = 1'b1; tick(); rst = 1'b0;
      check("rf_ready", 32'(dataReady), 0);
      check("rf_x1",    32'(x1), 0);
      check("rf_idx",   32'(sampleIdx), 0);
      check("rf_eof",   32'(flagEOF), 0);
      tick(); tick();
      check("rf_no_pulse", 32'(pulses - p0), 0);
      exp_cnt = 0; exp_ptr = 0;
      load_count(3);
      do_request("rf_after", 0, 0);

      // Oversized count saturates to DEPTH: full sweep, EOF at the last entry.
      for (int i = 3; i < DEPTH; i++) write_mem(i, i, -i, (i % 2 == 1) ? 1 : -1);
      load_count(DEPTH + 1);
      for (int i = 0; i < DEPTH; i++) do_request($sformatf("sat%0d", i), 0, 0);
      do_request("sat_wrap", 0, 0);

      check("sb_drained", 32'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
